// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage: PC register, IF/ID latch and BOOT/RUN/HALT control
module instruction_fetch #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          MEM_BYTES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        stall,
    input  logic        flush,
    input  logic [63:0] branch_target,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        fetch_error,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        fetch_error_q, fetch_error_d;

    logic [64:0] pc_end;
    logic        pc_legal;

    // One extra bit so a PC near 2^64 cannot wrap into the legal range.
    assign pc_end   = {1'b0, pc_q} + 65'd4;
    assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_end <= MEM_LIMIT);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        fetch_error_d = fetch_error_q;

        unique case (state_q)
            ST_BOOT: begin
                if_id_valid_d = 1'b0;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                if (flush) begin
                    pc_d          = branch_target;
                    if_id_valid_d = 1'b0;
                end else if (stall) begin
                    state_d = ST_RUN;
                end else if (pc_legal) begin
                    if_id_inst_d  = Instruction;
                    if_id_pc_d    = pc_q;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_q + 64'd4;
                end else begin
                    state_d       = ST_HALT;
                    fetch_error_d = 1'b1;
                    if_id_valid_d = 1'b0;
                end
            end
            ST_HALT: begin
                if_id_valid_d = 1'b0;
                if (flush) begin
                    pc_d          = branch_target;
                    fetch_error_d = 1'b0;
                    state_d       = ST_RUN;
                end
            end
            default: begin
                state_d       = ST_BOOT;
                if_id_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 64'd0;
            if_id_inst_q  <= 32'd0;
            if_id_valid_q <= 1'b0;
            fetch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_error_q <= fetch_error_d;
        end
    end

    assign Inst_Address = pc_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_inst   = if_id_inst_q;
    assign if_id_valid  = if_id_valid_q;
    assign fetch_error  = fetch_error_q;
    assign halted       = (state_q == ST_HALT);

endmodule
